// File: rtl/branch_predictor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor_pkg
// Purpose  : Shared constants for the fetch-side branch predictor: RISC-V
//            control-flow opcodes, 2-bit counter encodings and PC width.
// Revision : 1.0  initial release
// ============================================================================
package branch_predictor_pkg;

  localparam int XLEN = 32;

  // Control-flow opcodes as seen by the decoder feeding ex_is_branch/ex_is_jump
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] J      = 7'b1101111;
  localparam logic [6:0] JR     = 7'b1100111;

  // 2-bit saturating counter states; the MSB is the taken prediction
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage : branch_predictor_pkg
`default_nettype wire

// File: rtl/branch_predictor_sat_ctr2.sv
`default_nettype none
// ============================================================================
// Module   : sat_ctr2
// Purpose  : Next-state function of a 2-bit saturating counter. Moves toward
//            ST on taken and toward SNT on not-taken, holding at either end.
// Revision : 1.0  initial release
// ============================================================================
module sat_ctr2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_nxt
);

  // Saturating increment/decrement
  always_comb begin
    ctr_nxt = ctr;
    if (taken) begin
      if (ctr != ST) ctr_nxt = ctr + 2'd1;
    end else begin
      if (ctr != SNT) ctr_nxt = ctr - 2'd1;
    end
  end

endmodule : sat_ctr2
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped BTB with 2-bit counters. Predicts at IF, trains
//            from EX resolution, raises a registered redirect on mispredict
//            and keeps branch/mispredict performance counters.
// Revision : 1.0  initial release
// ============================================================================
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int XLEN    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            ex_valid,
  input  logic            ex_is_branch,
  input  logic            ex_is_jump,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            ex_taken,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  input  logic [XLEN-1:0] ex_pred_target,
  output logic            mispredict,
  output logic [XLEN-1:0] redirect_pc,
  output logic [31:0]     branch_count,
  output logic [31:0]     mispredict_count
);

  localparam int TAG_W = XLEN - IDX_W - 2;

  // Table storage
  logic             valid_q  [ENTRIES];
  logic             valid_d  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic             jmp_q    [ENTRIES];
  logic             jmp_d    [ENTRIES];

  // Redirect and counters
  logic             mispredict_q, mispredict_d;
  logic [XLEN-1:0]  redirect_pc_q, redirect_pc_d;
  logic [31:0]      branch_count_q, branch_count_d;
  logic [31:0]      mispredict_count_q, mispredict_count_d;

  logic [IDX_W-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0] if_tag, ex_tag;
  logic             if_hit, ex_hit;
  logic             res, detect;
  logic [XLEN-1:0]  ex_seq_pc;
  logic [1:0]       ctr_upd;

  // Word-aligned PCs: the low two bits never address the table
  logic unused_pc_bits;
  assign unused_pc_bits = ^{if_pc[1:0], ex_pc[1:0]};

  assign if_idx = if_pc[IDX_W+1:2];
  assign if_tag = if_pc[XLEN-1:IDX_W+2];
  assign ex_idx = ex_pc[IDX_W+1:2];
  assign ex_tag = ex_pc[XLEN-1:IDX_W+2];

  // IF lookup; reads the pre-update table even when EX writes the same slot
  always_comb begin
    if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    pred_taken  = if_hit && (jmp_q[if_idx] || ctr_q[if_idx][1]);
    pred_target = pred_taken ? target_q[if_idx] : if_pc + XLEN'(4);
  end

  // Resolution: compare the carried prediction against the real outcome
  always_comb begin
    ex_hit    = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    res       = ex_valid && (ex_is_branch || ex_is_jump);
    ex_seq_pc = ex_pc + XLEN'(4);
    detect    = (res && (ex_taken != ex_pred_taken))
             || (res && ex_taken && (ex_target != ex_pred_target))
             || (ex_valid && !ex_is_branch && !ex_is_jump && ex_pred_taken);
  end

  sat_ctr2 u_sat_ctr2 (
    .ctr     (ctr_q[ex_idx]),
    .taken   (ex_taken),
    .ctr_nxt (ctr_upd)
  );

  // Table training from EX; a jump takes the jump path if both flags are set
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    jmp_d    = jmp_q;
    if (res) begin
      if (ex_hit) begin
        if (ex_is_jump) begin
          target_d[ex_idx] = ex_target;
          jmp_d[ex_idx]    = 1'b1;
        end else begin
          ctr_d[ex_idx] = ctr_upd;
          if (ex_taken) target_d[ex_idx] = ex_target;
        end
      end else if (ex_taken) begin
        valid_d[ex_idx]  = 1'b1;
        tag_d[ex_idx]    = ex_tag;
        target_d[ex_idx] = ex_target;
        ctr_d[ex_idx]    = WT;
        jmp_d[ex_idx]    = ex_is_jump;
      end
    end else if (ex_valid && ex_hit) begin
      // A non-control-flow instruction aliased onto this entry: drop it
      valid_d[ex_idx] = 1'b0;
    end
  end

  // Redirect and performance counter next state
  always_comb begin
    mispredict_d       = detect;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (detect) begin
      redirect_pc_d      = (res && ex_taken) ? ex_target : ex_seq_pc;
      mispredict_count_d = mispredict_count_q + 32'd1;
    end
    if (res) branch_count_d = branch_count_q + 32'd1;
  end

  // Control state with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= WNT;
        jmp_q[i]   <= 1'b0;
      end
      mispredict_q       <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      valid_q            <= valid_d;
      ctr_q              <= ctr_d;
      jmp_q              <= jmp_d;
      mispredict_q       <= mispredict_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  // Tags and targets are only meaningful under valid, so they carry no reset
  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign mispredict       = mispredict_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Self-checking bench for branch_predictor: directed scenarios
//            followed by random traffic against a behavioural table model.
// Revision : 1.0  initial release
// ============================================================================
module tb_branch_predictor;

  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int XLEN    = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid, ex_is_branch, ex_is_jump;
  logic [31:0] ex_pc, ex_target, ex_pred_target;
  logic        ex_taken, ex_pred_taken;
  logic        mispredict;
  logic [31:0] redirect_pc, branch_count, mispredict_count;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_is_branch     (ex_is_branch),
    .ex_is_jump       (ex_is_jump),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid [ENTRIES];
  logic [31:0] m_tag   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  bit          m_jmp   [ENTRIES];
  bit          m_mis;
  logic [31:0] m_redir, m_bc, m_mc;

  function automatic int slot(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[slot(pc)] && (m_tag[slot(pc)] == tag_of(pc));
  endfunction

  function automatic bit m_pred(input logic [31:0] pc);
    return m_hit(pc) && (m_jmp[slot(pc)] || m_ctr[slot(pc)] >= 2);
  endfunction

  function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
    return m_pred(pc) ? m_tgt[slot(pc)] : pc + 32'd4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 0; m_ctr[i] = 1; m_jmp[i] = 0;
      m_tag[i] = '0; m_tgt[i] = '0;
    end
    m_mis = 0; m_redir = '0; m_bc = '0; m_mc = '0;
  endtask

  // Apply one clock edge's worth of architectural effect to the model
  task automatic model_edge();
    bit res, wrong, h;
    int s;
    res   = ex_valid && (ex_is_branch || ex_is_jump);
    wrong = (res && (ex_taken != ex_pred_taken))
         || (res && ex_taken && ex_target != ex_pred_target)
         || (ex_valid && !ex_is_branch && !ex_is_jump && ex_pred_taken);
    s = slot(ex_pc);
    h = m_hit(ex_pc);
    m_mis = wrong;
    if (wrong) begin
      m_redir = (res && ex_taken) ? ex_target : ex_pc + 32'd4;
      m_mc    = m_mc + 1;
    end
    if (res) m_bc = m_bc + 1;
    if (res) begin
      if (h) begin
        if (ex_is_jump) begin
          m_tgt[s] = ex_target; m_jmp[s] = 1;
        end else if (ex_taken) begin
          m_ctr[s] = (m_ctr[s] == 3) ? 3 : m_ctr[s] + 1;
          m_tgt[s] = ex_target;
        end else begin
          m_ctr[s] = (m_ctr[s] == 0) ? 0 : m_ctr[s] - 1;
        end
      end else if (ex_taken) begin
        m_valid[s] = 1; m_tag[s] = tag_of(ex_pc); m_tgt[s] = ex_target;
        m_ctr[s] = 2; m_jmp[s] = ex_is_jump;
      end
    end else if (ex_valid && h) begin
      m_valid[s] = 0;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0; ex_pc = '0;
    ex_taken = 0; ex_target = '0; ex_pred_taken = 0; ex_pred_target = '0;
  endtask

  // EX instruction whose carried prediction is what the table gave it
  task automatic set_ex(input bit br, input bit jp, input logic [31:0] pc,
                        input bit tk, input logic [31:0] tgt);
    ex_valid = 1; ex_is_branch = br; ex_is_jump = jp; ex_pc = pc;
    ex_taken = tk; ex_target = tgt;
    ex_pred_taken = m_pred(pc); ex_pred_target = m_ptgt(pc);
  endtask

  // Called just after a falling edge with inputs set; ends on the next one
  task automatic step();
    #1;
    check("pred_taken",  32'(pred_taken), 32'(m_pred(if_pc)));
    check("pred_target", pred_target, m_ptgt(if_pc));
    model_edge();
    @(posedge clk);
    #1;
    check("mispredict",       32'(mispredict), 32'(m_mis));
    check("redirect_pc",      redirect_pc, m_redir);
    check("branch_count",     branch_count, m_bc);
    check("mispredict_count", mispredict_count, m_mc);
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_pc();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC;
    return (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  function automatic logic [31:0] rand_tgt();
    case ($urandom_range(0, 3))
      0:       return 32'h80;
      1:       return 32'h90;
      2:       return 32'h400;
      default: return $urandom & 32'hFFFF_FFFC;
    endcase
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    idle();
    if_pc = '0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    if_pc = 32'h100;
    #1;
    check("rst_pred_taken",  32'(pred_taken), 32'd0);
    check("rst_pred_target", pred_target, 32'h104);
    check("rst_mispredict",  32'(mispredict), 32'd0);
    check("rst_bc",          branch_count, 32'd0);
    check("rst_mc",          mispredict_count, 32'd0);
    step();

    // Allocating taken branch at 0x100 -> 0x80
    set_ex(1, 0, 32'h100, 1, 32'h80);
    step();
    check("alloc_mis",   32'(mispredict), 32'd1);
    check("alloc_redir", redirect_pc, 32'h80);
    idle();
    step();
    check("alloc_mis_drop", 32'(mispredict), 32'd0);
    check("alloc_pred",     32'(pred_taken), 32'd1);
    check("alloc_ptgt",     pred_target, 32'h80);

    // Three not-taken resolutions: 10 -> 01 -> 00 -> 00
    repeat (3) begin
      set_ex(1, 0, 32'h100, 0, 32'h0);
      step();
    end
    idle();
    #1;
    check("nt_pred",   32'(pred_taken), 32'd0);
    check("nt_ctr_mc", mispredict_count, 32'd2);
    check("nt_ctr_bc", branch_count, 32'd4);

    // JAL at 0x200, alias lookup, then a false hit from a non-branch
    set_ex(0, 1, 32'h200, 1, 32'h400);
    step();
    idle();
    if_pc = 32'h200 + ENTRIES * 4;
    step();
    check("alias_pred", 32'(pred_taken), 32'd0);
    check("alias_ptgt", pred_target, 32'h244);
    if_pc = 32'h200;
    #1;
    check("jal_pred", 32'(pred_taken), 32'd1);
    check("jal_ptgt", pred_target, 32'h400);
    set_ex(0, 0, 32'h200, 0, 32'h0);
    step();
    check("false_hit_mis",   32'(mispredict), 32'd1);
    check("false_hit_redir", redirect_pc, 32'h204);
    idle();
    step();
    check("false_hit_inval", 32'(pred_taken), 32'd0);

    // Fall-through wraps at the top of the address space
    if_pc = 32'hFFFF_FFFC;
    step();
    check("wrap_ptgt", pred_target, 32'h0);

    // Taken to a different target than predicted
    set_ex(1, 0, 32'h300, 1, 32'h80);
    step();
    set_ex(1, 0, 32'h300, 1, 32'h90);
    step();
    check("tgt_mis",   32'(mispredict), 32'd1);
    check("tgt_redir", redirect_pc, 32'h90);
    idle();
    if_pc = 32'h300;
    #1;
    check("tgt_update", pred_target, 32'h90);

    // Asynchronous reset in the middle of an update cycle
    set_ex(1, 0, 32'h300, 0, 32'h0);
    #1;
    rst = 1'b1;
    #1;
    check("arst_mis",   32'(mispredict), 32'd0);
    check("arst_redir", redirect_pc, 32'd0);
    check("arst_bc",    branch_count, 32'd0);
    check("arst_mc",    mispredict_count, 32'd0);
    check("arst_pred",  32'(pred_taken), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    idle();
    if_pc = 32'h300;
    step();
    check("arst_after_pred", 32'(pred_taken), 32'd0);
    if_pc = 32'h100;
    step();

    // Random traffic
    for (int n = 0; n < 500; n++) begin
      int kind;
      logic [31:0] pc;
      kind = $urandom_range(0, 3);
      pc   = rand_pc();
      if_pc = ($urandom_range(0, 1) == 0) ? pc : rand_pc();
      case (kind)
        0:       set_ex(1, 0, pc, 1'($urandom_range(0, 1)), rand_tgt());
        1:       set_ex(0, 1, pc, 1, rand_tgt());
        2:       set_ex(0, 0, pc, 1'($urandom_range(0, 1)), rand_tgt());
        default: idle();
      endcase
      if ($urandom_range(0, 4) == 0) ex_valid = 0;
      if ($urandom_range(0, 3) == 0) begin
        ex_pred_taken  = 1'($urandom_range(0, 1));
        ex_pred_target = rand_tgt();
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_branch_predictor
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side branch predictor. It guesses the outcome and target of each instruction at the IF stage.
- It is trained by the branch-resolution result (taken/not-taken, i.e. PC_src) coming back from EX.
- It contains a direct-mapped BTB with 2-bit saturating counters, mispredict detection, registered redirect/flush generation, and performance counters.
- It sits between the PC register and the EX-stage branch resolution logic.

Parameters:
- ENTRIES, 16: number of BTB entries; power of two, at least 2.
- IDX_W, 4: index width, equal to log2(ENTRIES).
- XLEN, 32: PC and target width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_pc  in  XLEN  PC currently being fetched.
- pred_taken  out  1  prediction for if_pc; combinational.
- pred_target  out  XLEN  predicted next PC for if_pc; combinational.
- ex_valid  in  1  a valid instruction occupies EX this cycle.
- ex_is_branch  in  1  EX instruction is a conditional branch (opcode 1100011).
- ex_is_jump  in  1  EX instruction is JAL (1101111) or JALR (1100111).
- ex_pc  in  XLEN  PC of the EX instruction.
- ex_taken  in  1  resolved outcome; 1 = PC_src asserted.
- ex_target  in  XLEN  resolved target address.
- ex_pred_taken  in  1  pred_taken value carried down the pipe with this instruction.
- ex_pred_target  in  XLEN  pred_target value carried down the pipe with this instruction.
- mispredict  out  1  registered; flush IF/ID/EX and load redirect_pc.
- redirect_pc  out  XLEN  registered correct next PC.
- branch_count  out  32  count of resolved branches and jumps.
- mispredict_count  out  32  count of mispredictions.

Behaviour:
- Entry fields: valid, tag (XLEN-IDX_W-2 bits), target (XLEN), ctr (2 bits), jmp (1 bit).
- Addressing: idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Lookup (combinational):
  - hit = valid[idx] & (tag[idx] == if_pc tag).
  - pred_taken = hit & (jmp[idx] | ctr[idx][1]).
  - pred_target = pred_taken ? target[idx] : if_pc+4. Arithmetic is mod 2^XLEN, so 0xFFFFFFFC+4 = 0.
- res = ex_valid & (ex_is_branch | ex_is_jump).
- Mispredict detection (computed in the same cycle):
  - res & (ex_taken != ex_pred_taken); or
  - res & ex_taken & (ex_target != ex_pred_target); or
  - ex_valid & ~ex_is_branch & ~ex_is_jump & ex_pred_taken (alias false hit).
- Redirect registers, updated at the next edge:
  - mispredict <= detect.
  - redirect_pc <= (res & ex_taken) ? ex_target : ex_pc+4.
  - When detect=0, mispredict <= 0 and redirect_pc holds its value.
  - Latency: 1 cycle after EX. The pipeline flushes every instruction younger than the resolved one.
- Table update, on the edge when res=1, at index/tag from ex_pc:
  - Hit, conditional branch: ctr saturating-increments if taken and decrements if not (11 stays 11, 00 stays 00). If taken, target <= ex_target.
  - Hit, jump: target <= ex_target; jmp <= 1.
  - Miss and ex_taken=1: allocate/overwrite the entry with valid=1, tag, target=ex_target, ctr=10, jmp=ex_is_jump.
  - Miss and ex_taken=0: no change.
- Table update when ex_valid=1, not a branch/jump, and a hit on ex_pc: valid[idx] <= 0.
- No bypass: when IF and EX touch the same index in one cycle, the lookup sees the pre-update entry.
- Counters, both 32-bit and wrapping:
  - branch_count += 1 when res=1.
  - mispredict_count += 1 when detect=1.
- Reset (asynchronous, takes effect immediately, including mid-update): all valid=0, ctr=01, jmp=0, mispredict=0, redirect_pc=0, both counters=0. Targets and tags need no reset.
- With ex_valid=0, no state changes except mispredict dropping to 0.

Decomposition:
- Shared package holds:
  - opcode constants BRANCH=7'b1100011, J=7'b1101111, JR=7'b1100111;
  - counter encodings SNT=00, WNT=01, WT=10, ST=11;
  - XLEN.
- One sub-module, sat_ctr2: a 2-bit saturating counter next-state function, instantiated in the update path.

Test Plan:
- Reset, then if_pc=0x100 -> pred_taken=0, pred_target=0x104; mispredict=0; both counters 0.
- Branch at 0x100 resolves taken to 0x80 with pred_taken=0 -> the next cycle has mispredict=1 and redirect_pc=0x80, then mispredict=0; afterwards if_pc=0x100 gives pred_taken=1 and pred_target=0x80 (ctr=10).
- Same branch resolves not-taken twice -> ctr goes 10→01→00 and the prediction becomes not-taken; a further not-taken leaves ctr at 00; mispredict_count=2 and branch_count=4 (including the allocating branch).
- JAL at 0x200 to 0x400, then an alias at 0x200+ENTRIES*4 with a different tag -> the alias predicts not-taken (miss); a non-branch at 0x200 that was predicted taken produces mispredict, redirect_pc=0x204, and the entry is invalidated.
- Predicted taken to 0x80 but resolved taken to 0x90 -> mispredict=1, redirect_pc=0x90, and the stored target updates to 0x90.
- rst asserted during an update cycle -> outputs are 0 immediately, all subsequent lookups miss, and counters read 0.
